// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobe, column sync, frame debounce, one hex code per press.
// Latency: key_valid pulses one cycle after the end of the DEBOUNCE_FRAMES-th identical frame.
// Backpressure: none; key_valid is a single-cycle strobe with no ready, consumers must capture it.
//
// Ports:
//   clk       system clock (48 MHz nominal)
//   rst_n     asynchronous active-low reset
//   kp_col    column lines, active-low, asynchronous (2-flop synchronized internally)
//   kp_row    row drive, one row low at a time: 1110, 1101, 1011, 0111
//   key_code  last accepted key, {row[1:0], col[1:0]}
//   key_valid one-cycle strobe when key_code is (re)issued
//   key_held  high while the accepted key remains pressed
//   num1..4   entry digit history, newest in num1
//
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held:
// first repeat after REPEAT_DELAY frames, then every REPEAT_RATE frames.

module keypad_scan #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kp_col,
    output logic [3:0] kp_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_FRAMES);

    // Sampling on the slot's last cycle through a 2-flop synchronizer only sees the
    // current row if the slot is at least 3 cycles long.
    if (SCAN_DIV < 3)        begin : g_chk_div  $error("SCAN_DIV must be >= 3");        end
    if (DEBOUNCE_FRAMES < 1) begin : g_chk_db   $error("DEBOUNCE_FRAMES must be >= 1"); end
    if (REPEAT_DELAY < 1)    begin : g_chk_dly  $error("REPEAT_DELAY must be >= 1");    end
    if (REPEAT_RATE < 1)     begin : g_chk_rate $error("REPEAT_RATE must be >= 1");     end

    typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_t;
    typedef enum logic {S_RELEASED, S_HELD} state_t;

    logic [3:0]    col_s1, col_s2;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    row_idx;
    logic [11:0]   press_lo;      // rows 0..2 of the frame in progress
    logic          slot_last, frame_end;

    logic [15:0]   frame_vec;
    logic [4:0]    n_pressed;
    logic [3:0]    hit_code;
    cand_t         cand_kind, prev_kind;
    logic [3:0]    prev_code;
    logic [DW-1:0] stab_cnt, stab_nxt;
    logic          same_cand, stable, accept;
    state_t        state;

    assign kp_row    = ~(4'b0001 << row_idx);
    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_last && (row_idx == 2'd3);

    // ---------------- row strobe and column capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1   <= 4'hF;
            col_s2   <= 4'hF;
            slot_cnt <= '0;
            row_idx  <= '0;
            press_lo <= '0;
        end else begin
            col_s1 <= kp_col;
            col_s2 <= col_s1;
            if (slot_last) begin
                slot_cnt <= '0;
                row_idx  <= row_idx + 2'd1;
                case (row_idx)
                    2'd0:    press_lo[3:0]  <= ~col_s2;
                    2'd1:    press_lo[7:4]  <= ~col_s2;
                    2'd2:    press_lo[11:8] <= ~col_s2;
                    default: ;  // row 3 is consumed directly at frame end
                endcase
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

    // ---------------- frame candidate ----------------
    // Bit index = row*4 + col, which is exactly the key code.
    always_comb begin
        frame_vec = {~col_s2, press_lo};
        n_pressed = '0;
        hit_code  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_vec[i]) begin
                n_pressed = n_pressed + 5'd1;
                hit_code  = 4'(i);
            end
        end
        if (n_pressed == 5'd0)      cand_kind = CAND_NONE;
        else if (n_pressed == 5'd1) cand_kind = CAND_KEY;
        else                        cand_kind = CAND_MULTI;
    end

    // ---------------- stability count ----------------
    always_comb begin
        same_cand = (cand_kind == prev_kind) &&
                    ((cand_kind != CAND_KEY) || (hit_code == prev_code));
        if (cand_kind == CAND_MULTI)  stab_nxt = '0;
        else if (!same_cand)          stab_nxt = DW'(1);
        else if (stab_cnt == DB_MAX)  stab_nxt = DB_MAX;
        else                          stab_nxt = stab_cnt + DW'(1);
        stable = (stab_nxt == DB_MAX);
        // A new key is accepted from RELEASED, or from HELD when it differs from the current one.
        accept = frame_end && stable && (cand_kind == CAND_KEY) &&
                 ((state == S_RELEASED) || (hit_code != key_code));
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt, rep_inc;
    logic          rep_fast;   // first repeat already issued, now at REPEAT_RATE cadence
    logic          rep_due;
    assign rep_inc = rep_cnt + RW'(1);
    assign rep_due = rep_fast ? (rep_inc == RW'(REPEAT_RATE)) : (rep_inc == RW'(REPEAT_DELAY));
`endif

    // ---------------- press/release FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RELEASED;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            num1      <= '0;
            num2      <= '0;
            num3      <= '0;
            num4      <= '0;
            prev_kind <= CAND_NONE;
            prev_code <= '0;
            stab_cnt  <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_fast  <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                prev_kind <= cand_kind;
                prev_code <= hit_code;
                stab_cnt  <= stab_nxt;
                if (accept) begin
                    state     <= S_HELD;
                    key_code  <= hit_code;
                    key_valid <= 1'b1;
                    key_held  <= 1'b1;
                    num1      <= hit_code;
                    num2      <= num1;
                    num3      <= num2;
                    num4      <= num3;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt   <= '0;
                    rep_fast  <= 1'b0;
`endif
                end else begin
                    case (state)
                        S_RELEASED: ;
                        S_HELD: begin
                            if (stable && (cand_kind == CAND_NONE)) begin
                                state    <= S_RELEASED;
                                key_held <= 1'b0;
                            end
`ifdef KEYPAD_REPEAT_EN
                            else if (rep_due) begin
                                key_valid <= 1'b1;
                                num1      <= key_code;
                                num2      <= num1;
                                num3      <= num2;
                                num4      <= num3;
                                rep_cnt   <= '0;
                                rep_fast  <= 1'b1;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
`endif
                        end
                        default: state <= S_RELEASED;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed scenarios plus randomized key sequences
// compared against a frame-level reference model.
// Build with +define+KEYPAD_REPEAT_EN to exercise the auto-repeat variant.

module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int RDELAY   = 8;
    localparam int RRATE    = 4;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int C_NONE   = 16;
    localparam int C_MULTI  = 17;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] kp_col, kp_row, key_code, num1, num2, num3, num4;
    logic       key_valid, key_held;

    logic [15:0] pressed = '0;     // ideal keypad: bit row*4+col set = key down
    logic        bounce_on = 1'b0; // masks bounce_key while set
    int          bounce_key = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DB),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .kp_col(kp_col), .kp_row(kp_row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4)
    );

    // Passive matrix: a column is pulled low if a pressed key connects it to the driven row.
    always_comb begin
        kp_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp_row[r] && pressed[r*4+c] && !(bounce_on && (r*4+c) == bounce_key))
                    kp_col[c] = 1'b0;
    end

    // Strobe monitor
    logic [3:0] got_q[$];
    int         got_cyc[$];
    int         b2b = 0;
    logic       last_vld = 1'b0;
    always @(negedge clk) begin
        if (key_valid) begin
            got_q.push_back(key_code);
            got_cyc.push_back(cyc);
        end
        if (key_valid && last_vld) b2b++;
        last_vld = key_valid;
    end

    // ---------------- frame-level reference model ----------------
    int         m_prev, m_cnt, m_rep;
    bit         m_held, m_rptg;
    logic [3:0] m_code;
    logic [3:0] m_num[4];
    logic [3:0] exp_q[$];

    function automatic int cand_of(input logic [15:0] m);
        int n, idx;
        n = 0; idx = C_NONE;
        for (int i = 0; i < 16; i++) if (m[i]) begin n++; idx = i; end
        if (n == 0) return C_NONE;
        if (n > 1)  return C_MULTI;
        return idx;
    endfunction

    task automatic model_emit(input logic [3:0] code);
        exp_q.push_back(code);
        m_num[3] = m_num[2]; m_num[2] = m_num[1]; m_num[1] = m_num[0]; m_num[0] = code;
    endtask

    task automatic model_frame(input int cand);
        bit stable;
        if (cand == C_MULTI)     m_cnt = 0;
        else if (cand == m_prev) m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
        else                     m_cnt = 1;
        m_prev = cand;
        stable = (m_cnt == DB);
        if (stable && cand < 16 && (!m_held || cand != int'(m_code))) begin
            m_held = 1; m_code = cand[3:0]; m_rep = 0; m_rptg = 0;
            model_emit(m_code);
        end else if (m_held && stable && cand == C_NONE) begin
            m_held = 0;
        end else if (m_held) begin
`ifdef KEYPAD_REPEAT_EN
            m_rep++;
            if (m_rep == (m_rptg ? RRATE : RDELAY)) begin
                m_rep = 0; m_rptg = 1;
                model_emit(m_code);
            end
`endif
        end
    endtask

    task automatic model_reset();
        m_prev = C_NONE; m_cnt = 0; m_rep = 0; m_held = 0; m_rptg = 0; m_code = '0;
        for (int i = 0; i < 4; i++) m_num[i] = '0;
        exp_q.delete();
    endtask

    // ---------------- timing helpers ----------------
    // Returns 1 time unit after the posedge on which row 0 starts a new frame.
    task automatic align();
        logic [3:0] last;
        bit found;
        last = kp_row; found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(posedge clk); #1;
            if (kp_row == 4'b1110 && last == 4'b0111) found = 1;
            last = kp_row;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL align: row scan never wrapped, kp_row=%b", kp_row);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (FRAME * n) @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        got_q.delete();
        got_cyc.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] exp_rows[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (kp_row !== 4'b1110) $display("FAIL reset_row: got %b want 1110", kp_row); else n_pass++;
        n_checks++; if (key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code); else n_pass++;
        n_checks++; if (key_valid !== 1'b0 || key_held !== 1'b0)
            $display("FAIL reset_flags: got vld=%b held=%b want 0 0", key_valid, key_held); else n_pass++;
        n_checks++; if ({num4, num3, num2, num1} !== 16'h0000)
            $display("FAIL reset_nums: got %h want 0000", {num4, num3, num2, num1}); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_checks++; if (kp_row !== 4'b1110) $display("FAIL row_after_rst: got %b want 1110", kp_row); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            n_checks++; if (kp_row !== exp_rows[k])
                $display("FAIL row_step%0d: got %b want %b", k, kp_row, exp_rows[k]); else n_pass++;
        end
    endtask

    task automatic test_single_press();
        int c0;
        align();
        clear_seen();
        c0 = cyc;
        pressed = 16'h1 << 9;
        run_frames(10);
        n_checks++; if (got_q.size() !== 1) $display("FAIL single_pulses: got %0d want 1", got_q.size()); else n_pass++;
        if (got_cyc.size() > 0) begin
            n_checks++; if (got_cyc[0] !== c0 + FRAME * DB)
                $display("FAIL single_latency: got cycle %0d want %0d", got_cyc[0] - c0, FRAME * DB); else n_pass++;
        end
        n_checks++; if (key_code !== 4'h9) $display("FAIL single_code: got %h want 9", key_code); else n_pass++;
        n_checks++; if (num1 !== 4'h9) $display("FAIL single_num1: got %h want 9", num1); else n_pass++;
        n_checks++; if (key_held !== 1'b1) $display("FAIL single_held: got %b want 1", key_held); else n_pass++;
        pressed = '0;
        repeat (FRAME * DB - 1) @(posedge clk);
        #1;
        n_checks++; if (key_held !== 1'b1) $display("FAIL release_early: got held=%b want 1", key_held); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (key_held !== 1'b0) $display("FAIL release_held: got held=%b want 0", key_held); else n_pass++;
        repeat (FRAME * (10 - DB)) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() !== 1) $display("FAIL release_pulse: got %0d pulses want 1", got_q.size()); else n_pass++;
    endtask

    task automatic test_bounce();
        align();
        clear_seen();
        bounce_key = 9;
        pressed = 16'h1 << 9;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i % 5 == 0) bounce_on = ~bounce_on;
            @(posedge clk);
        end
        #1;
        bounce_on = 1'b0;
        run_frames(8);
        n_checks++; if (got_q.size() !== 1) $display("FAIL bounce_pulses: got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== 4'h9) $display("FAIL bounce_code: got %h want 9", got_q[0]); else n_pass++;
        end
        pressed = '0;
        run_frames(5);
    endtask

    task automatic test_multi();
        clear_seen();
        pressed = (16'h1 << 0) | (16'h1 << 4);
        run_frames(10);
        n_checks++; if (got_q.size() !== 0) $display("FAIL multi_pulses: got %0d want 0", got_q.size()); else n_pass++;
        n_checks++; if (key_held !== 1'b0) $display("FAIL multi_held: got %b want 0", key_held); else n_pass++;
        n_checks++; if (key_code !== 4'h9) $display("FAIL multi_code: got %h want 9", key_code); else n_pass++;
        pressed = '0;
        run_frames(5);
    endtask

    task automatic test_entry_and_reset();
        align();
        clear_seen();
        for (int k = 1; k <= 5; k++) begin
            pressed = 16'h1 << k;
            run_frames(5);
            pressed = '0;
            run_frames(5);
        end
        n_checks++; if (got_q.size() !== 5) $display("FAIL entry_pulses: got %0d want 5", got_q.size()); else n_pass++;
        n_checks++; if ({num4, num3, num2, num1} !== 16'h2345)
            $display("FAIL entry_digits: got %h want 2345", {num4, num3, num2, num1}); else n_pass++;
        pressed = 16'h1 << 6;
        run_frames(4);
        n_checks++; if (key_held !== 1'b1 || key_code !== 4'h6)
            $display("FAIL pre_reset: got held=%b code=%h want 1 6", key_held, key_code); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({key_code, num4, num3, num2, num1} !== 20'h0 || key_valid !== 1'b0 ||
                        key_held !== 1'b0 || kp_row !== 4'b1110)
            $display("FAIL midpress_reset: got code=%h nums=%h vld=%b held=%b row=%b want all 0 row 1110",
                     key_code, {num4, num3, num2, num1}, key_valid, key_held, kp_row);
        else n_pass++;
        repeat (3) @(posedge clk);
        clear_seen();
        @(negedge clk) rst_n = 1'b1;
        repeat (6 * FRAME) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() !== 1) $display("FAIL held_thru_reset_pulses: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (key_code !== 4'h6 || num1 !== 4'h6 || num2 !== 4'h0 || key_held !== 1'b1)
            $display("FAIL held_thru_reset: got code=%h num1=%h num2=%h held=%b want 6 6 0 1",
                     key_code, num1, num2, key_held);
        else n_pass++;
        pressed = '0;
        align();
        run_frames(5);
    endtask

    task automatic test_repeat();
        align();
        clear_seen();
        model_reset();
        m_cnt = DB;                // idle and settled on NONE
        pressed = 16'h1 << 10;
        for (int f = 0; f < 20; f++) model_frame(10);
        run_frames(20);
        pressed = '0;
        for (int f = 0; f < 5; f++) model_frame(C_NONE);
        run_frames(5);
        n_checks++; if (got_q.size() !== exp_q.size())
            $display("FAIL repeat_pulses: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i])
                $display("FAIL repeat_code%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
`ifdef KEYPAD_REPEAT_EN
        if (got_cyc.size() >= 3) begin
            n_checks++; if (got_cyc[1] - got_cyc[0] !== FRAME * RDELAY)
                $display("FAIL repeat_delay: got %0d cycles want %0d", got_cyc[1] - got_cyc[0], FRAME * RDELAY); else n_pass++;
            n_checks++; if (got_cyc[2] - got_cyc[1] !== FRAME * RRATE)
                $display("FAIL repeat_rate: got %0d cycles want %0d", got_cyc[2] - got_cyc[1], FRAME * RRATE); else n_pass++;
        end
`endif
        n_checks++; if (num1 !== 4'hA) $display("FAIL repeat_num1: got %h want a", num1); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int kind, k1, k2, nf, cand;
        pressed = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        clear_seen();
        align();
        model_frame(C_NONE);       // the one idle frame consumed by align()
        for (int e = 0; e < 14; e++) begin
            kind = $urandom_range(0, 5);
            k1   = $urandom_range(0, 15);
            k2   = (k1 + $urandom_range(1, 15)) % 16;
            nf   = $urandom_range(1, 6);
            if (kind == 0)      mask = '0;
            else if (kind == 1) mask = (16'h1 << k1) | (16'h1 << k2);
            else                mask = 16'h1 << k1;
            pressed = mask;
            cand = cand_of(mask);
            for (int f = 0; f < nf; f++) model_frame(cand);
            run_frames(nf);
        end
        pressed = '0;
        for (int f = 0; f < 5; f++) model_frame(C_NONE);
        run_frames(5);
        n_checks++; if (got_q.size() !== exp_q.size())
            $display("FAIL rand_pulses: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i])
                $display("FAIL rand_code%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if ({num4, num3, num2, num1} !== {m_num[3], m_num[2], m_num[1], m_num[0]})
            $display("FAIL rand_digits: got %h want %h", {num4, num3, num2, num1},
                     {m_num[3], m_num[2], m_num[1], m_num[0]});
        else n_pass++;
        n_checks++; if (key_code !== m_code || key_held !== m_held)
            $display("FAIL rand_final: got code=%h held=%b want %h %b", key_code, key_held, m_code, m_held); else n_pass++;
        n_checks++; if (b2b !== 0) $display("FAIL back_to_back: got %0d adjacent strobes want 0", b2b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_entry_and_reset();
        test_repeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
